int_ctrl: RTL

Interrupt request controller directly upstream of the CP0 register block. It synchronises and edge-detects three external interrupt lines and holds them as pending requests. Using CP0's IE and INM outputs, it selects the highest-priority unmasked request and drives the interrupt code, break/NIE controls and handler vector into CP0 and the fetch stage. It tracks one in-service interrupt until `eret`.

---
 rtl/int_ctrl_pkg.sv | 29 ++
 rtl/int_ctrl_if.sv | 33 +++
 rtl/int_ctrl_irq_sync.sv | 42 ++++
 rtl/int_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt request controller.
// Holds the FSM state encoding, request count, code width and the
// fixed-priority helper used to pick the winning request.
package int_pkg;

  localparam int NUM_IRQ = 3;
  localparam int CODE_W  = 2;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    SERV = 2'd2,
    RET  = 2'd3
  } state_t;

  // Index of the highest set bit; higher index means higher priority.
  // Returns 0 when nothing is set (callers gate on "any request").
  function automatic code_t prio_idx(input logic [NUM_IRQ-1:0] req);
    code_t idx;
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req[i]) idx = code_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bus between the interrupt controller and its CP0 / pipeline neighbours.
// in_*  : request lines, CP0 enable/mask, eret and stall into the controller.
// out_* : interrupt code, BK/NIE controls, flush/redirect/vector, pending debug.
interface int_ctrl_if;
  import int_pkg::*;

  logic [NUM_IRQ-1:0] in_IRQ;
  logic               in_IE;
  logic [3:0]         in_INM;
  logic               in_eret;
  logic               in_stall;

  code_t              out_code;
  logic               out_BK;
  logic               out_NIE;
  logic               out_flush;
  logic               out_redirect;
  logic [31:0]        out_vector;
  logic [NUM_IRQ-1:0] out_pending;

  // master: the environment (CP0, pipeline, request sources)
  modport master (
    output in_IRQ, in_IE, in_INM, in_eret, in_stall,
    input  out_code, out_BK, out_NIE, out_flush, out_redirect, out_vector, out_pending
  );

  // slave: the interrupt controller itself
  modport slave (
    input  in_IRQ, in_IE, in_INM, in_eret, in_stall,
    output out_code, out_BK, out_NIE, out_flush, out_redirect, out_vector, out_pending
  );

endinterface

// File: rtl/int_ctrl_irq_sync.sv
// Synchroniser and rising-edge detector for one asynchronous request line.
// Ports: in_CLK/in_RST (async, active-high), irq (async line), rise (one-cycle
// registered pulse per synchronised rising edge). SYNC_STAGES must be >= 2.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic in_CLK,
  input  logic in_RST,
  input  logic irq,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   hist_q;
  logic                   low_seen_q;
  logic                   armed;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // The chain resets to zeros, so its output is only a real sample of the
  // line once the reset zeros have been flushed through.
  assign armed    = fill_q[SYNC_STAGES-1];

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      sync_q     <= '0;
      fill_q     <= '0;
      hist_q     <= 1'b0;
      low_seen_q <= 1'b0;
      rise       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], irq};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q     <= sync_out;
      // A line held high through reset must fall before any edge counts.
      low_seen_q <= low_seen_q | (armed & ~sync_out);
      rise       <= armed & low_seen_q & sync_out & ~hist_q;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt request controller feeding CP0: pends edge-detected requests,
// picks the highest-priority unmasked one and sequences take/service/return.
// Ports: in_CLK, in_RST (async, active-high), bus (int_ctrl_if.slave).
module int_ctrl
  import int_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_1000,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0100
) (
  input  logic           in_CLK,
  input  logic           in_RST,
  int_ctrl_if.slave      bus
);

  state_t             state_q, state_d;
  code_t              cur_q, cur_d;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic               eligible;
  logic               take_done;
  logic               inm_unused;

  // Mask bit 3 has no request line behind it.
  assign inm_unused = bus.in_INM[3];

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .in_CLK (in_CLK),
      .in_RST (in_RST),
      .irq    (bus.in_IRQ[i]),
      .rise   (rise[i])
    );
  end

  assign eligible_vec = pending_q & ~bus.in_INM[NUM_IRQ-1:0];
  assign eligible     = bus.in_IE & (|eligible_vec);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    take_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          cur_d   = prio_idx(eligible_vec);
          state_d = TAKE;
        end
      end
      // Once in TAKE the request is committed: mask/IE changes are ignored.
      TAKE: begin
        if (!bus.in_stall) begin
          take_done = 1'b1;
          state_d   = SERV;
        end
      end
      // No nesting: new requests wait until the handler returns.
      SERV: begin
        if (bus.in_eret) state_d = RET;
      end
      // One cycle of code 0 so CP0 sees a fresh rising edge on the next take.
      RET: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state_q <= IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  assign clr_vec = take_done ? (3'b001 << cur_q) : 3'b000;

  // A new edge landing on the cycle its bit is cleared re-pends it.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) pending_q <= '0;
    else        pending_q <= (pending_q & ~clr_vec) | rise;
  end

  assign bus.out_code     = (state_q == TAKE || state_q == SERV) ? code_t'(cur_q + 2'd1) : '0;
  assign bus.out_flush    = (state_q == TAKE);
  assign bus.out_BK       = take_done;
  assign bus.out_redirect = take_done;
  assign bus.out_NIE      = ~take_done;
  assign bus.out_vector   = VEC_BASE + VEC_STRIDE * {30'd0, cur_q};
  assign bus.out_pending  = pending_q;

endmodule
